// File: rtl/spi_frame_pkg.sv
// Shared constants and types for the SPI frame receiver.
// Frame layout (MSB first): [15]=rw (1=write), [14:8]=addr, [7:0]=data.
package spi_frame_pkg;

  localparam int FRAME_BITS = 16;
  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;
  localparam int ERR_CNT_W  = 8;

  localparam int RW_BIT     = 15;
  localparam int ADDR_MSB   = 14;
  localparam int ADDR_LSB   = 8;
  localparam int DATA_MSB   = 7;
  localparam int DATA_LSB   = 0;

  // Bit counter counts 0..FRAME_BITS+1, where FRAME_BITS+1 means "too long"
  localparam int CNT_W = $clog2(FRAME_BITS + 2);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/spi_frame_rx_if.sv
// Frame output port of the SPI receiver: valid/ready plus frame fields.
// master = receiver side, slave = register bank side.
interface spi_frame_rx_if;
  import spi_frame_pkg::*;

  logic              frame_valid_o;
  logic              frame_ready_i;
  logic              frame_wr_o;
  logic [ADDR_W-1:0] frame_addr_o;
  logic [DATA_W-1:0] frame_data_o;

  modport master (
    output frame_valid_o, frame_wr_o, frame_addr_o, frame_data_o,
    input  frame_ready_i
  );

  modport slave (
    input  frame_valid_o, frame_wr_o, frame_addr_o, frame_data_o,
    output frame_ready_i
  );

endinterface

// File: rtl/spi_frame_rx_sync.sv
// Multi-flop synchronizer for one asynchronous pin; resets to the pin's idle level.
module sync_ff #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_pipe;

  // Shift the pin through STAGES flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pipe <= {STAGES{RST_VAL}};
    else     r_pipe <= {r_pipe[STAGES-2:0], i_d};
  end

  assign o_q = r_pipe[STAGES-1];

endmodule

// File: rtl/spi_frame_rx.sv
// SPI mode-0 frame deserializer: synchronizes SCLK/COPI/nCS, shifts 16-bit
// MSB-first frames and hands complete frames out on a valid/ready port.
// Malformed (wrong length) and overrun frames are dropped with a one-cycle
// frame_err_o pulse.
// Optional: define SPI_FRAME_ERR_CNT_EN to add err_cnt_o, a saturating
// count of frame_err_o pulses.
module spi_frame_rx
  import spi_frame_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sclk_i,
  input  logic                 copi_i,
  input  logic                 ncs_i,
  spi_frame_rx_if.master       frm,
  output logic                 frame_err_o,
  output logic                 busy_o
`ifdef SPI_FRAME_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt_o
`endif
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  logic w_sclk_s, w_copi_s, w_ncs_s;

  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .i_d(sclk_i), .o_q(w_sclk_s));
  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst(rst), .i_d(copi_i), .o_q(w_copi_s));
  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst(rst), .i_d(ncs_i),  .o_q(w_ncs_s));

  // Edge detection (registered pulses, copi delayed to stay aligned)
  logic                   r_sclk_d, r_ncs_d, r_copi_d;
  logic                   r_sclk_rise, r_ncs_rise, r_ncs_fall;
  logic [SYNC_STAGES-1:0] r_settle;
  logic                   r_armed;

  // Detect synced edges. A frame start is only accepted once nCS has been
  // seen high with real pin data in the synchronizer, so a reset that lands
  // mid-frame cannot turn the still-low nCS into a bogus fresh frame start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_d    <= 1'b0;
      r_ncs_d     <= 1'b1;
      r_copi_d    <= 1'b0;
      r_sclk_rise <= 1'b0;
      r_ncs_rise  <= 1'b0;
      r_ncs_fall  <= 1'b0;
      r_settle    <= '0;
      r_armed     <= 1'b0;
    end else begin
      r_sclk_d    <= w_sclk_s;
      r_ncs_d     <= w_ncs_s;
      r_copi_d    <= w_copi_s;
      r_sclk_rise <= w_sclk_s & ~r_sclk_d;
      r_ncs_rise  <= w_ncs_s & ~r_ncs_d;
      r_ncs_fall  <= r_armed & ~w_ncs_s & r_ncs_d;
      r_settle    <= {r_settle[SYNC_STAGES-2:0], 1'b1};
      if (r_settle[SYNC_STAGES-1] && w_ncs_s) r_armed <= 1'b1;
    end
  end

  // FSM
  state_t r_state, w_state_nxt;
  logic   w_start, w_end, w_shift_en;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state: nCS fall opens a frame, nCS rise closes it
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (r_ncs_fall) w_state_nxt = SHIFT;
      SHIFT:   if (r_ncs_rise) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs: sclk edges only matter while in SHIFT
  always_comb begin
    busy_o     = (r_state == SHIFT);
    w_start    = (r_state == IDLE)  & r_ncs_fall;
    w_end      = (r_state == SHIFT) & r_ncs_rise;
    w_shift_en = (r_state == SHIFT) & r_sclk_rise;
  end

  // Shift register / bit counter
  logic [FRAME_BITS-1:0] r_sh, w_sh_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic                  r_valid, r_wr, r_err;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_data;
  logic                  w_xfer, w_load, w_err;

  // Post-shift view so a same-cycle sclk rise is counted before the length check
  always_comb begin
    w_sh_nxt  = r_sh;
    w_cnt_nxt = r_cnt;
    if (w_shift_en) begin
      w_sh_nxt = {r_sh[FRAME_BITS-2:0], r_copi_d};
      if (r_cnt != CNT_SAT) w_cnt_nxt = r_cnt + 1'b1;
    end
    w_xfer = r_valid & frm.frame_ready_i;
    // A transfer in the same cycle frees the holding register for the new frame
    w_load = w_end & (w_cnt_nxt == CNT_FULL) & (~r_valid | w_xfer);
    w_err  = w_end & ~w_load;
  end

  // Shift data in; count restarts on each frame start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh  <= '0;
      r_cnt <= '0;
    end else if (w_start) begin
      r_sh  <= '0;
      r_cnt <= '0;
    end else begin
      r_sh  <= w_sh_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  // Output holding register and handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_err;
      if (w_load) begin
        r_valid <= 1'b1;
        r_wr    <= w_sh_nxt[RW_BIT];
        r_addr  <= w_sh_nxt[ADDR_MSB:ADDR_LSB];
        r_data  <= w_sh_nxt[DATA_MSB:DATA_LSB];
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign frm.frame_valid_o = r_valid;
  assign frm.frame_wr_o    = r_wr;
  assign frm.frame_addr_o  = r_addr;
  assign frm.frame_data_o  = r_data;
  assign frame_err_o       = r_err;

`ifdef SPI_FRAME_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] r_err_cnt;

  // Saturating count of dropped frames
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   r_err_cnt <= '0;
    else if (r_err && (r_err_cnt != '1))       r_err_cnt <= r_err_cnt + 1'b1;
  end

  assign err_cnt_o = r_err_cnt;
`endif

endmodule
